// File: rtl/rk8e_sd_xfer_if.sv
// Command, data-break and SD byte-stream signals of the RK8-E sector engine.
// The master side is the engine, the slave side is controller, memory and driver.
interface rk8e_sd_xfer_if;
    logic        start;
    logic        wr_cmd;
    logic [1:0]  drive;
    logic [12:0] block;
    logic        half;
    logic [0:2]  field;
    logic [0:11] car_in;
    logic        busy;
    logic        done;
    logic        error;
    logic [0:11] car_out;
    logic [0:14] db_addr;
    logic [0:11] db_wdata;
    logic [0:11] db_rdata;
    logic        data_break_write;
    logic        data_break_read;
    logic        db_ack;
    logic        sd_rd_req;
    logic        sd_wr_req;
    logic [31:0] sd_lba;
    logic        sd_ack;
    logic [7:0]  sd_rd_data;
    logic        sd_rd_valid;
    logic        sd_rd_ready;
    logic [7:0]  sd_wr_data;
    logic        sd_wr_valid;
    logic        sd_wr_ready;
    logic        sd_done;
    logic        sd_err;

    modport master (
        input  start, wr_cmd, drive, block, half, field, car_in,
        output busy, done, error, car_out,
        output db_addr, db_wdata, data_break_write, data_break_read,
        input  db_rdata, db_ack,
        output sd_rd_req, sd_wr_req, sd_lba, sd_rd_ready,
        output sd_wr_data, sd_wr_valid,
        input  sd_ack, sd_rd_data, sd_rd_valid, sd_wr_ready,
        input  sd_done, sd_err
    );

    modport slave (
        output start, wr_cmd, drive, block, half, field, car_in,
        input  busy, done, error, car_out,
        input  db_addr, db_wdata, data_break_write, data_break_read,
        output db_rdata, db_ack,
        input  sd_rd_req, sd_wr_req, sd_lba, sd_rd_ready,
        input  sd_wr_data, sd_wr_valid,
        output sd_ack, sd_rd_data, sd_rd_valid, sd_wr_ready,
        output sd_done, sd_err
    );
endinterface

// File: rtl/rk8e_sd_xfer.sv
// RK05 sector <-> SD block transfer engine: 256 12-bit words as
// 512 little-endian bytes, memory reached through data-break cycles.
module rk8e_sd_xfer #(
    parameter logic [31:0] LBA_BASE       = 32'd0,
    parameter int unsigned BLKS_PER_DRIVE = 6496
) (
    input  logic           clk,
    input  logic           reset,
    rk8e_sd_xfer_if.master bus
);
    localparam logic [31:0] BPD = 32'(BLKS_PER_DRIVE);

    typedef enum logic [3:0] {
        IDLE, RD_REQ, RD_LO, RD_HI, RD_BRK, RD_WAIT,
        WR_REQ, WR_FETCH, WR_LO, WR_HI, WR_WAIT, FIN
    } state_e;

    state_e      state_q, state_d;
    logic        wr_q, wr_d;
    logic        half_q, half_d;
    logic [2:0]  field_q, field_d;
    logic [11:0] car_q, car_d;
    logic [11:0] word_q, word_d;
    logic [8:0]  wcnt_q, wcnt_d;
    logic        abort_q, abort_d;
    logic        busy_q, busy_d;
    logic        error_q, error_d;
    logic [11:0] cout_q, cout_d;
    logic [31:0] lba_q, lba_d;

    logic [8:0]  lim;
    logic        in_lim;
    logic        brk_wr;
    logic        brk_rd;
    logic        oor;
    logic        unused_hi;

    assign lim    = half_q ? 9'd128 : 9'd256;
    assign in_lim = wcnt_q < lim;
    assign brk_wr = state_q == RD_BRK;
    assign brk_rd = (state_q == WR_FETCH) && in_lim;
    assign oor    = {19'd0, bus.block} >= BPD;
    assign unused_hi = ^bus.sd_rd_data[7:4] ^ wr_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            wr_q    <= 1'b0;
            half_q  <= 1'b0;
            field_q <= '0;
            car_q   <= '0;
            word_q  <= '0;
            wcnt_q  <= '0;
            abort_q <= 1'b0;
            busy_q  <= 1'b0;
            error_q <= 1'b0;
            cout_q  <= '0;
            lba_q   <= '0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            half_q  <= half_d;
            field_q <= field_d;
            car_q   <= car_d;
            word_q  <= word_d;
            wcnt_q  <= wcnt_d;
            abort_q <= abort_d;
            busy_q  <= busy_d;
            error_q <= error_d;
            cout_q  <= cout_d;
            lba_q   <= lba_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wr_d    = wr_q;
        half_d  = half_q;
        field_d = field_q;
        car_d   = car_q;
        word_d  = word_q;
        wcnt_d  = wcnt_q;
        abort_d = abort_q;
        busy_d  = busy_q;
        error_d = error_q;
        cout_d  = cout_q;
        lba_d   = lba_q;
        unique case (state_q)
            IDLE: if (bus.start) begin
                wr_d    = bus.wr_cmd;
                half_d  = bus.half;
                field_d = bus.field;
                car_d   = bus.car_in;
                lba_d   = LBA_BASE + {30'd0, bus.drive} * BPD
                        + {19'd0, bus.block};
                wcnt_d  = '0;
                abort_d = 1'b0;
                busy_d  = 1'b1;
                error_d = oor;
                if (oor) state_d = FIN;
                else     state_d = bus.wr_cmd ? WR_REQ : RD_REQ;
            end
            RD_REQ: if (bus.sd_ack) state_d = RD_LO;
            RD_LO: if (bus.sd_rd_valid) begin
                word_d[7:0] = bus.sd_rd_data;
                state_d     = RD_HI;
            end
            RD_HI: if (bus.sd_rd_valid) begin
                word_d[11:8] = bus.sd_rd_data[3:0];
                wcnt_d       = wcnt_q + 9'd1;
                if (in_lim)                 state_d = RD_BRK;
                else if (wcnt_q == 9'd255)  state_d = RD_WAIT;
                else                        state_d = RD_LO;
            end
            RD_BRK: if (bus.db_ack) begin
                car_d   = car_q + 12'd1;
                state_d = (wcnt_q == 9'd256) ? RD_WAIT : RD_LO;
            end
            RD_WAIT, WR_WAIT: if (bus.sd_done) state_d = FIN;
            WR_REQ: if (bus.sd_ack) state_d = WR_FETCH;
            WR_FETCH: if (!in_lim) begin
                word_d  = '0;
                state_d = WR_LO;
            end else if (bus.db_ack) begin
                word_d  = bus.db_rdata;
                car_d   = car_q + 12'd1;
                state_d = WR_LO;
            end
            WR_LO: if (bus.sd_wr_ready) state_d = WR_HI;
            WR_HI: if (bus.sd_wr_ready) begin
                wcnt_d  = wcnt_q + 9'd1;
                state_d = (wcnt_q == 9'd255) ? WR_WAIT : WR_FETCH;
            end
            FIN: begin
                busy_d  = 1'b0;
                cout_d  = car_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // a break already on the bus must see its ack before aborting
        if (state_q != IDLE && state_q != FIN && (bus.sd_err || abort_q)) begin
            if ((brk_wr || brk_rd) && !bus.db_ack) begin
                abort_d = 1'b1;
            end else begin
                abort_d = 1'b0;
                error_d = 1'b1;
                state_d = FIN;
            end
        end
    end

    assign bus.busy             = busy_q;
    assign bus.done             = state_q == FIN;
    assign bus.error            = error_q;
    assign bus.car_out          = cout_q;
    assign bus.db_addr          = (brk_wr || brk_rd) ? {field_q, car_q} : '0;
    assign bus.db_wdata         = word_q;
    assign bus.data_break_write = brk_wr;
    assign bus.data_break_read  = brk_rd;
    assign bus.sd_rd_req        = state_q == RD_REQ;
    assign bus.sd_wr_req        = state_q == WR_REQ;
    assign bus.sd_lba           = lba_q;
    assign bus.sd_rd_ready      = (state_q == RD_LO) || (state_q == RD_HI);
    assign bus.sd_wr_valid      = (state_q == WR_LO) || (state_q == WR_HI);
    assign bus.sd_wr_data       = (state_q == WR_LO) ? word_q[7:0]
                                : (state_q == WR_HI) ? {4'b0, word_q[11:8]}
                                : 8'h00;
endmodule

// File: tb/tb_rk8e_sd_xfer.sv
// Directed bench for rk8e_sd_xfer with behavioural memory and SD driver.
module tb_rk8e_sd_xfer;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    rk8e_sd_xfer_if bus();

    rk8e_sd_xfer #(.LBA_BASE(32'd0), .BLKS_PER_DRIVE(6496)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    int total = 0;
    int bad = 0;

    logic [11:0] mem [0:32767];
    logic [14:0] wa_log [0:511];
    logic [11:0] wd_log [0:511];
    logic [7:0]  wb [0:511];
    int nw, nr, ri, wi, err_at, ndone, both_cnt;
    bit rd_on, wr_on, err_sent, rtake, rdq_seen;
    logic [7:0] lo_b, hi_b;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // responders: memory break slave and SD driver, all driven on negedge
    initial begin
        bus.db_ack = 0; bus.db_rdata = '0; bus.sd_ack = 0;
        bus.sd_rd_data = 0; bus.sd_rd_valid = 0; bus.sd_wr_ready = 0;
        bus.sd_done = 0; bus.sd_err = 0;
        forever begin
            @(negedge clk);
            if (bus.data_break_read && bus.data_break_write) both_cnt++;
            if (bus.sd_rd_req) rdq_seen = 1;
            if (bus.done) ndone++;
            if (bus.db_ack) bus.db_ack = 0;
            else if (bus.data_break_write) begin
                wa_log[nw[8:0]] = bus.db_addr;
                wd_log[nw[8:0]] = bus.db_wdata;
                nw++;
                bus.db_ack = 1;
            end else if (bus.data_break_read) begin
                bus.db_rdata = mem[bus.db_addr];
                nr++;
                bus.db_ack = 1;
            end
            if (bus.sd_ack) bus.sd_ack = 0;
            else if (bus.sd_rd_req || bus.sd_wr_req) bus.sd_ack = 1;
            bus.sd_err = 0;
            if (rtake) ri++;
            if (rd_on && ri == err_at && !err_sent) begin
                bus.sd_err = 1;
                err_sent = 1;
            end
            bus.sd_rd_valid = rd_on && ri < 512 && !err_sent;
            bus.sd_rd_data = ri[0] ? hi_b : lo_b;
            rtake = bus.sd_rd_valid && bus.sd_rd_ready;
            bus.sd_wr_ready = wr_on ? ~bus.sd_wr_ready : 1'b0;
            if (bus.sd_wr_valid && bus.sd_wr_ready && wi < 512) begin
                wb[wi] = bus.sd_wr_data;
                wi++;
            end
            bus.sd_done = ((rd_on && ri == 512) || (wr_on && wi == 512))
                          && !bus.done;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic setup(input bit rd, input bit wr);
        nw = 0; nr = 0; ri = 0; wi = 0; err_at = -1;
        err_sent = 0; rtake = 0; rdq_seen = 0;
        rd_on = rd; wr_on = wr;
    endtask

    task automatic go(input bit w, input int drv, input int blk, input bit h,
                      input logic [2:0] fld, input logic [11:0] car);
        bus.wr_cmd = w; bus.drive = 2'(drv); bus.block = 13'(blk);
        bus.half = h; bus.field = fld; bus.car_in = car;
        bus.start = 1;
        @(negedge clk);
        bus.start = 0;
    endtask

    task automatic wait_done(input int max, output bit ok, output int cyc);
        ok = 0;
        cyc = 0;
        for (int i = 0; i < max; i++) begin
            if (bus.done) begin
                ok = 1;
                break;
            end
            cyc++;
            @(negedge clk);
        end
    endtask

    initial begin
        bit ok;
        int cyc, d0, errs;
        logic [7:0] eb;
        bus.start = 0; bus.wr_cmd = 0; bus.drive = 0; bus.block = 0;
        bus.half = 0; bus.field = 0; bus.car_in = 0;
        nw = 0; nr = 0; ri = 0; wi = 0; ndone = 0; both_cnt = 0;
        rd_on = 0; wr_on = 0; lo_b = 8'h34; hi_b = 8'h12;
        for (int i = 0; i < 32768; i++) mem[i] = '0;
        repeat (3) @(negedge clk);
        chk("rst_ctl", {bus.busy, bus.done, bus.error, bus.sd_rd_req,
            bus.sd_wr_req, bus.data_break_read, bus.data_break_write,
            bus.sd_wr_valid, bus.sd_rd_ready}, 0);
        chk("rst_car", {bus.car_out, bus.db_addr}, 0);
        chk("rst_lba", bus.sd_lba, 0);
        reset = 1;
        @(negedge clk);

        // full read, drive 1 block 5, field 2, car 7770 (wraps)
        setup(1, 0);
        d0 = ndone;
        go(0, 1, 5, 0, 3'd2, 12'o7770);
        chk("rd_busy", bus.busy, 1);
        wait_done(4000, ok, cyc);
        chk("rd_done", ok, 1);
        @(negedge clk);
        chk("rd_nw", nw, 256);
        errs = 0;
        for (int i = 0; i < 256; i++) begin
            if (wa_log[i] !== {3'd2, 12'(12'o7770 + i)}) errs++;
            if (wd_log[i] !== 12'o1064) errs++;
        end
        chk("rd_log", errs, 0);
        chk("rd_first", wa_log[0], 15'o27770);
        chk("rd_last", wa_log[255], 15'o20367);
        chk("rd_lba", bus.sd_lba, 6501);
        chk("rd_car", bus.car_out, 12'o0370);
        chk("rd_err", bus.error, 0);
        chk("rd_busy0", bus.busy, 0);
        chk("rd_pulse", ndone - d0, 1);

        // half write, drive 2 block 10, with a start pulse while busy
        for (int i = 0; i < 128; i++) mem[{3'd3, 12'(12'o0100 + i)}] = 12'(i);
        setup(0, 1);
        d0 = ndone;
        go(1, 2, 10, 1, 3'd3, 12'o0100);
        repeat (20) @(negedge clk);
        go(0, 0, 1, 0, 3'd0, 12'o0);
        wait_done(6000, ok, cyc);
        chk("wr_done", ok, 1);
        @(negedge clk);
        chk("wr_nr", nr, 128);
        chk("wr_wi", wi, 512);
        errs = 0;
        for (int j = 0; j < 512; j++) begin
            eb = (j < 256 && j[0] == 1'b0) ? 8'(j / 2) : 8'h00;
            if (wb[j] !== eb) errs++;
        end
        chk("wr_bytes", errs, 0);
        chk("wr_b254", wb[254], 8'h7f);
        chk("wr_lba", bus.sd_lba, 13002);
        chk("wr_car", bus.car_out, 12'o0300);
        chk("wr_err", bus.error, 0);
        chk("wr_pulse", ndone - d0, 1);

        // block out of range
        setup(1, 0);
        go(0, 0, 6496, 0, 3'd0, 12'o0);
        wait_done(3, ok, cyc);
        chk("oor_done", ok, 1);
        chk("oor_lat", cyc <= 2, 1);
        @(negedge clk);
        chk("oor_err", bus.error, 1);
        chk("oor_noreq", rdq_seen, 0);

        // SD error after 100 bytes of a read
        setup(1, 0);
        err_at = 100;
        go(0, 0, 0, 0, 3'd0, 12'o0);
        wait_done(2000, ok, cyc);
        chk("se_done", ok, 1);
        @(negedge clk);
        chk("se_err", bus.error, 1);
        chk("se_nw", nw, 50);
        chk("se_car", bus.car_out, 50);
        chk("se_idle", {bus.busy, bus.sd_rd_req, bus.sd_rd_ready,
            bus.data_break_write, bus.data_break_read}, 0);

        // recovery: half read, drive 3 last block
        setup(1, 0);
        go(0, 3, 6495, 1, 3'd1, 12'o4000);
        chk("rc_err0", bus.error, 0);
        wait_done(4000, ok, cyc);
        chk("rc_done", ok, 1);
        @(negedge clk);
        chk("rc_err", bus.error, 0);
        chk("rc_lba", bus.sd_lba, 25983);
        chk("rc_nw", nw, 128);
        chk("rc_car", bus.car_out, 12'o4200);

        // reset in the middle of a write
        setup(0, 1);
        go(1, 0, 2, 0, 3'd0, 12'o0);
        repeat (40) @(negedge clk);
        chk("mr_busy", bus.busy, 1);
        reset = 0;
        #1;
        chk("mr_ctl", {bus.busy, bus.done, bus.error, bus.sd_rd_req,
            bus.sd_wr_req, bus.data_break_read, bus.data_break_write,
            bus.sd_wr_valid, bus.sd_rd_ready}, 0);
        chk("mr_car", {bus.car_out, bus.db_addr}, 0);
        chk("mr_lba", bus.sd_lba, 0);
        setup(0, 0);
        @(negedge clk);
        reset = 1;
        repeat (3) @(negedge clk);
        chk("mr_idle", {bus.busy, bus.sd_wr_valid, bus.data_break_read}, 0);

        chk("one_brk", both_cnt, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
